lpf_decimator: RTL

- Downstream stage of LowpassFilter. Takes its 16-bit offset-binary output stream, where 0x0000 = -1.0, 0x8000 = 0.0 and 0xFFFF ≈ +1.0 (LSB = 2^-15).
- Decimates the stream by DECIM and buffers the kept samples in a small FIFO.
- Presents the kept samples on a valid/ready interface to the consumer, optionally converted to two's complement.
- Sits between the filter output and the capture/serial-out logic.

---
 rtl/lpf_pkg.sv | 12 +
 rtl/sync_fifo.sv | 78 +++++++
 rtl/lpf_decimator.sv | 86 ++++++++
 3 files changed

// File: rtl/lpf_pkg.sv
// Shared types and constants for the LowpassFilter output path.
// Samples are offset binary: 0x0000 = -1.0, 0x8000 = 0.0, LSB = 2^-15.
package lpf_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t ZERO_LEVEL = 16'h8000;
  localparam real     LSB_SCALE  = 1.0 / 32768.0;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head output.
// rdata is reloaded on the same edge that changes the head, so a write into an empty FIFO is visible one edge later.
module sync_fifo #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RDATA_RST = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [LW-1:0]    remaining;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LW'(DEPTH));
  assign pop_ok    = pop && !empty;
  assign remaining = count_q - LW'(pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + LW'(push) - LW'(pop_ok);
      // The new head is either the word being written right now (FIFO drains to zero
      // this cycle) or the stored word at the advanced read pointer; an empty FIFO holds.
      if (count_d != '0) begin
        rdata_d = (push && remaining == '0) ? wdata : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= RDATA_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign level = count_q;

endmodule

// File: rtl/lpf_decimator.sv
// Keeps every DECIM-th valid filter sample, buffers it in a small FIFO and
// presents it on a valid/ready output, optionally as two's complement.
//
// Handshake: a sample transfers on any cycle where out_valid && out_ready;
// out_valid never depends on out_ready, and out_ready is ignored while empty.
module lpf_decimator
  import lpf_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter bit TWOS_OUT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DATA_W-1:0] MSB_ONLY = {1'b1, {(DATA_W-1){1'b0}}};
  // Head register resets to the raw value that converts to an all-zero output.
  localparam logic [DATA_W-1:0] HEAD_RST = TWOS_OUT ? MSB_ONLY : '0;

  logic [PW-1:0]     phase_q, phase_d;
  logic              overflow_q, overflow_d;
  logic              keep, pop, push;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;

  assign keep = in_valid && (phase_q == '0);
  assign pop  = out_valid && out_ready && !clear;
  assign push = keep && (!fifo_full || pop) && !clear;

  always_comb begin
    phase_d    = phase_q;
    overflow_d = overflow_q;
    if (clear) begin
      phase_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (in_valid) begin
        phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
      end
      if (keep && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH     (DATA_W),
    .DEPTH     (FIFO_DEPTH),
    .RDATA_RST (HEAD_RST)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (in),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign out_data  = TWOS_OUT ? {~head[DATA_W-1], head[DATA_W-2:0]} : head;

endmodule
